// File: rtl/display_source_arbiter_if.sv
// Bundle between the application datapaths, the display source arbiter and the display controller.
// The master side drives the requests and data. The slave side (the arbiter) drives the grant and display outputs.
interface display_source_arbiter_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]    req;
    logic [16*N_SRC-1:0] src_data;
    logic                lock;
    logic [N_SRC-1:0]    grant;
    logic [2:0]          src_idx;
    logic                display_valid;
    logic [15:0]         displayed_num;
    logic                switch_pulse;

    modport master (
        output req, src_data, lock,
        input  grant, src_idx, display_valid, displayed_num, switch_pulse
    );

    modport slave (
        input  req, src_data, lock,
        output grant, src_idx, display_valid, displayed_num, switch_pulse
    );
endinterface

// File: rtl/display_source_arbiter.sv
// Round-robin sharing of the seven-segment display between N_SRC sources.
// Each grant is held for a minimum dwell time before it rotates.
module display_source_arbiter #(
    parameter int          N_SRC        = 4,
    parameter int          DWELL_CYCLES = 100_000_000,
    parameter int          CNT_W        = 27,
    parameter logic [15:0] IDLE_VALUE   = 16'h0000
) (
    input logic                     clk,
    input logic                     rst,
    display_source_arbiter_if.slave bus
);
    typedef enum logic {IDLE, SHOW} state_t;

    state_t           state, next_state;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0] dwell_cnt, dwell_d;
    logic [15:0]      num_q, num_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;

    logic [N_SRC-1:0] others;
    logic [N_SRC-1:0] rotated;
    logic             other_found;
    logic [2:0]       other_idx;
    logic             cur_req;
    logic             expired;
    logic             new_grant;
    logic [2:0]       new_idx;
    logic [15:0]      cur_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            rr_ptr    <= '0;
            dwell_cnt <= '0;
            num_q     <= IDLE_VALUE;
            valid_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state     <= next_state;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            rr_ptr    <= rr_ptr_d;
            dwell_cnt <= dwell_d;
            num_q     <= num_d;
            valid_q   <= valid_d;
            pulse_q   <= pulse_d;
        end
    end

    // The current holder is masked out of the search; since rr_ptr sits just past it,
    // it would have been found last anyway, so expiry falls back to a re-grant.
    always_comb begin
        others      = bus.req & ~grant_q;
        rotated     = N_SRC'({others, others} >> rr_ptr);
        other_found = 1'b0;
        other_idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!other_found && rotated[k]) begin
                other_found = 1'b1;
                other_idx   = 3'((int'(rr_ptr) + k) % N_SRC);
            end
        end

        cur_req    = |(bus.req & grant_q);
        expired    = (dwell_cnt == CNT_W'(DWELL_CYCLES - 1));
        next_state = state;
        new_grant  = 1'b0;
        new_idx    = idx_q;

        case (state)
            IDLE: begin
                if (other_found) begin
                    next_state = SHOW;
                    new_grant  = 1'b1;
                    new_idx    = other_idx;
                end
            end
            SHOW: begin
                if (!cur_req) begin
                    if (other_found) begin
                        new_grant = 1'b1;
                        new_idx   = other_idx;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (expired && !bus.lock) begin
                    new_grant = 1'b1;
                    new_idx   = other_found ? other_idx : idx_q;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // displayed_num follows the source held during the cycle just ending, so it lags grant by one edge.
    always_comb begin
        cur_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (idx_q == 3'(i)) cur_data = bus.src_data[16*i +: 16];
        end

        grant_d  = grant_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr;
        dwell_d  = dwell_cnt;
        num_d    = num_q;
        valid_d  = valid_q;
        pulse_d  = 1'b0;

        if (next_state == IDLE) begin
            grant_d = '0;
            idx_d   = '0;
            dwell_d = '0;
            num_d   = IDLE_VALUE;
            valid_d = 1'b0;
        end else begin
            valid_d = 1'b1;
            num_d   = (state == SHOW) ? cur_data : IDLE_VALUE;
            if (new_grant) begin
                for (int i = 0; i < N_SRC; i++) grant_d[i] = (new_idx == 3'(i));
                idx_d    = new_idx;
                pulse_d  = 1'b1;
                dwell_d  = '0;
                rr_ptr_d = (new_idx == 3'(N_SRC - 1)) ? 3'd0 : new_idx + 3'd1;
            end else if (!expired) begin
                dwell_d = dwell_cnt + 1'b1;
            end
        end
    end

    assign bus.grant         = grant_q;
    assign bus.src_idx       = idx_q;
    assign bus.display_valid = valid_q;
    assign bus.displayed_num = num_q;
    assign bus.switch_pulse  = pulse_q;
endmodule

// File: tb/tb_display_source_arbiter.sv
// Scoreboard bench for display_source_arbiter with N_SRC=4 and a dwell of 4 cycles.
// Stimulus pushes hand-computed expectations; a monitor pops them on each falling edge.
module tb_display_source_arbiter;
    logic clk;
    logic rst;

    display_source_arbiter_if #(.N_SRC(4)) bus ();

    display_source_arbiter #(
        .N_SRC       (4),
        .DWELL_CYCLES(4),
        .CNT_W       (2),
        .IDLE_VALUE  (16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  grant;
        logic        pulse;
        logic [15:0] num;
        logic        check_num;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] sd[4]    = '{16'hA000, 16'hB111, 16'hBEEF, 16'hD333};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] idx_of(input logic [3:0] g);
        idx_of = 3'd0;
        for (int i = 0; i < 4; i++) if (g[i]) idx_of = 3'(i);
    endfunction

    task automatic compare(input string name, input string tag, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%h required=%h at %0t", tag, name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compare("grant", e.tag, 16'(bus.grant), 16'(e.grant));
        compare("src_idx", e.tag, 16'(bus.src_idx), 16'(idx_of(e.grant)));
        compare("display_valid", e.tag, 16'(bus.display_valid), 16'(|e.grant));
        compare("switch_pulse", e.tag, 16'(bus.switch_pulse), 16'(e.pulse));
        if (e.check_num) compare("displayed_num", e.tag, bus.displayed_num, e.num);
    endtask

    // One call covers one rising edge: inputs before it, expected outputs after it.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic lk,
                                 input logic [3:0] eg, input logic ep, input logic [15:0] en,
                                 input logic cn, input string tag);
        exp_t e;
        @(negedge clk);
        #1;
        rst     = r;
        bus.req = rq;
        bus.lock = lk;
        e.grant = eg;
        e.pulse = ep;
        e.num = en;
        e.check_num = cn;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic reset_dut();
        applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b1, "reset");
        applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b1, "post_reset");
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        rst          = 1'b1;
        bus.req      = '0;
        bus.lock     = 1'b0;
        bus.src_data = {sd[3], sd[2], sd[1], sd[0]};

        // Idle after reset for 20 cycles
        applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b1, "s1_rst");
        for (int c = 0; c < 20; c++)
            applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b1, "s1_idle");

        // Sole requester 2: re-grant pulse every 4 cycles
        for (int c = 0; c < 9; c++)
            applyStimulus(1'b0, 4'b0100, 1'b0, 4'b0100, 1'((c % 4) == 0), 16'hBEEF,
                          1'((c % 4) != 0), "s2_single");
        reset_dut();

        // All requesting: order 0,1,2,3,0
        for (int c = 0; c < 17; c++)
            applyStimulus(1'b0, 4'b1111, 1'b0, 4'(4'b0001 << ((c / 4) % 4)), 1'((c % 4) == 0),
                          sd[((c + 3) / 4 + 3) % 4], 1'((c % 4) != 0), "s3_rr");
        reset_dut();

        // Holder drops, another pending: switch without an idle cycle, then drop to idle
        applyStimulus(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 16'h0000, 1'b0, "s4_grant1");
        applyStimulus(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 16'hB111, 1'b1, "s4_hold1");
        applyStimulus(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 16'h0000, 1'b0, "s4_switch");
        applyStimulus(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 16'hD333, 1'b1, "s4_hold3");
        applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b1, "s4_drop_idle");
        reset_dut();

        // Lock suppresses expiry rotation and re-grant
        applyStimulus(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 16'h0000, 1'b0, "s5_grant0");
        for (int c = 1; c < 6; c++)
            applyStimulus(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 16'hA000, 1'b1, "s5_locked");
        for (int c = 0; c < 2; c++)
            applyStimulus(1'b0, 4'b0101, 1'b1, 4'b0001, 1'b0, 16'hA000, 1'b1, "s5_locked_req2");
        applyStimulus(1'b0, 4'b0101, 1'b0, 4'b0100, 1'b1, 16'h0000, 1'b0, "s5_unlock");
        applyStimulus(1'b0, 4'b0101, 1'b0, 4'b0100, 1'b0, 16'hBEEF, 1'b1, "s5_after");
        reset_dut();

        // Reset mid-grant restores rr_ptr to 0
        applyStimulus(1'b0, 4'b0110, 1'b0, 4'b0010, 1'b1, 16'h0000, 1'b0, "s6_grant1");
        for (int c = 1; c < 4; c++)
            applyStimulus(1'b0, 4'b0110, 1'b0, 4'b0010, 1'b0, 16'hB111, 1'b1, "s6_hold1");
        applyStimulus(1'b0, 4'b0110, 1'b0, 4'b0100, 1'b1, 16'h0000, 1'b0, "s6_rot2");
        applyStimulus(1'b0, 4'b0110, 1'b0, 4'b0100, 1'b0, 16'hBEEF, 1'b1, "s6_hold2");
        applyStimulus(1'b1, 4'b0110, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b1, "s6_reset");
        applyStimulus(1'b0, 4'b0110, 1'b0, 4'b0010, 1'b1, 16'h0000, 1'b0, "s6_regrant1");
        applyStimulus(1'b0, 4'b0110, 1'b0, 4'b0010, 1'b0, 16'hB111, 1'b1, "s6_after");

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
